// File: rtl/audio_pkg.sv
// Shared types and constants for the sample playback path.
package audio_pkg;

    localparam int unsigned DataW        = 16;
    localparam int unsigned DefaultAddrW = 17;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StPlay,
        StFinish
    } fetch_state_e;

endpackage

// File: rtl/fetch_addr_gen.sv
// Fetch address stepper with end-of-range detection.
// Optional wrap-to-start is compiled in when SAMPLE_FETCH_LOOP_EN is defined.
module fetch_addr_gen
    import audio_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
`ifdef SAMPLE_FETCH_LOOP_EN
    input  logic              loop_i,
`endif
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] base;
    logic              is_end;
    logic              wrap;

    // On load the range comes straight from the inputs so the first read can go out at once.
    assign base   = load_i ? start_addr_i : addr_q;
    assign is_end = base == (load_i ? end_addr_i : end_q);

`ifdef SAMPLE_FETCH_LOOP_EN
    logic [ADDR_W-1:0] start_q;
    logic              loop_q;
    logic              loop_sel;

    assign loop_sel = load_i ? loop_i : loop_q;
    assign wrap     = is_end && loop_sel;

    // Loop range registers, captured on an accepted start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_q <= '0;
            loop_q  <= 1'b0;
        end else if (load_i) begin
            start_q <= start_addr_i;
            loop_q  <= loop_i;
        end
    end

    // Next address: wrap back to start after end_addr while looping.
    always_comb begin
        addr_d = addr_q;
        done_d = done_q;
        if (step_i) begin
            addr_d = wrap ? (load_i ? start_addr_i : start_q) : base + ADDR_W'(1);
            done_d = is_end && !loop_sel;
        end else if (load_i) begin
            addr_d = start_addr_i;
            done_d = 1'b0;
        end
    end
`else
    assign wrap = 1'b0;

    // Next address: plain increment; end_addr marks the range exhausted (no wrap to 0).
    always_comb begin
        addr_d = addr_q;
        done_d = done_q;
        if (step_i) begin
            addr_d = base + ADDR_W'(1);
            done_d = is_end;
        end else if (load_i) begin
            addr_d = start_addr_i;
            done_d = 1'b0;
        end
    end
`endif

    // Address, end and exhausted-range registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            end_q  <= '0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            done_q <= done_d;
            if (load_i) begin
                end_q <= end_addr_i;
            end
        end
    end

    assign addr_o = base;
    assign last_o = is_end && !wrap;
    assign done_o = done_q;

endmodule

// File: rtl/sample_fetcher.sv
// Sample ROM fetcher: reads a word range from ROM and feeds a serializer through a
// one-word prefetch. Define SAMPLE_FETCH_LOOP_EN to add the loop_i port and looping playback.
module sample_fetcher
    import audio_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DATA_W = DataW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
`ifdef SAMPLE_FETCH_LOOP_EN
    input  logic              loop_i,
`endif
    input  logic              word_taken_i,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              play_enable_o,
    output logic              busy_o,
    output logic              underrun_o
);

    fetch_state_e      state_q, state_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rvalid_q, rvalid_d;       // rom_data_i carries a word this cycle
    logic              tag_q, tag_d;             // in-flight read is the final word
    logic [DATA_W-1:0] data_q, data_d;
    logic              cur_last_q, cur_last_d;
    logic [DATA_W-1:0] pref_q, pref_d;
    logic              pref_last_q, pref_last_d;
    logic              pref_valid_q, pref_valid_d;
    logic              take_pend_q, take_pend_d; // consumed word awaiting its successor
    logic              play_q, play_d;
    logic              underrun_q, underrun_d;

    logic              issue;
    logic              gen_load;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last;
    logic              gen_done;

    fetch_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (gen_load),
        .step_i       (issue),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
`ifdef SAMPLE_FETCH_LOOP_EN
        .loop_i       (loop_i),
`endif
        .addr_o       (gen_addr),
        .last_o       (gen_last),
        .done_o       (gen_done)
    );

    // Next-state, prefetch and read-issue logic.
    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        gen_load     = 1'b0;
        rvalid_d     = rom_en_q;
        data_d       = data_q;
        cur_last_d   = cur_last_q;
        pref_d       = pref_q;
        pref_last_d  = pref_last_q;
        pref_valid_d = pref_valid_q;
        take_pend_d  = take_pend_q;
        play_d       = play_q;
        underrun_d   = underrun_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && (start_addr_i <= end_addr_i)) begin
                    gen_load     = 1'b1;
                    issue        = 1'b1;
                    underrun_d   = 1'b0;
                    take_pend_d  = 1'b0;
                    pref_valid_d = 1'b0;
                    state_d      = StPrime;
                end
            end
            StPrime: begin
                if (rvalid_q) begin
                    data_d     = rom_data_i;
                    cur_last_d = tag_q;
                    play_d     = 1'b1;
                    issue      = !gen_done;
                    state_d    = StPlay;
                end
            end
            StPlay: begin
                if (word_taken_i && cur_last_q) begin
                    play_d  = 1'b0;
                    state_d = StFinish;
                end else begin
                    if (word_taken_i && pref_valid_q) begin
                        data_d       = pref_q;
                        cur_last_d   = pref_last_q;
                        pref_valid_d = 1'b0;
                    end else if (word_taken_i) begin
                        underrun_d  = 1'b1;
                        take_pend_d = 1'b1;
                    end
                    // A returning word skips the prefetch slot if the serializer is waiting.
                    if (rvalid_q) begin
                        if (take_pend_d) begin
                            data_d      = rom_data_i;
                            cur_last_d  = tag_q;
                            take_pend_d = 1'b0;
                        end else begin
                            pref_d       = rom_data_i;
                            pref_last_d  = tag_q;
                            pref_valid_d = 1'b1;
                        end
                    end
                    // Single outstanding read, and only when the slot will be free for it.
                    issue = !gen_done && !rom_en_q && !rvalid_q && !pref_valid_d;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // stop wins over anything decided above, including a simultaneous word_taken.
        if (stop_i && (state_q != StIdle)) begin
            state_d      = StIdle;
            issue        = 1'b0;
            rvalid_d     = 1'b0;
            data_d       = data_q;
            cur_last_d   = cur_last_q;
            pref_valid_d = 1'b0;
            take_pend_d  = 1'b0;
            play_d       = 1'b0;
            underrun_d   = underrun_q;
        end

        rom_en_d   = issue;
        rom_addr_d = issue ? gen_addr : rom_addr_q;
        tag_d      = issue ? gen_last : tag_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            rvalid_q     <= 1'b0;
            tag_q        <= 1'b0;
            data_q       <= '0;
            cur_last_q   <= 1'b0;
            pref_q       <= '0;
            pref_last_q  <= 1'b0;
            pref_valid_q <= 1'b0;
            take_pend_q  <= 1'b0;
            play_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            rvalid_q     <= rvalid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            cur_last_q   <= cur_last_d;
            pref_q       <= pref_d;
            pref_last_q  <= pref_last_d;
            pref_valid_q <= pref_valid_d;
            take_pend_q  <= take_pend_d;
            play_q       <= play_d;
            underrun_q   <= underrun_d;
        end
    end

    assign rom_en_o      = rom_en_q;
    assign rom_addr_o    = rom_addr_q;
    assign data_out_o    = data_q;
    assign play_enable_o = play_q;
    assign busy_o        = state_q != StIdle;
    assign underrun_o    = underrun_q;

endmodule
